riscv_mem_arbiter: RTL and testbench

- Shares one single-ported backing memory between the core's instruction-fetch port (icache side) and data port (dcache side).
- Serialises requests, one outstanding transaction at a time. Data has priority, with a bounded-starvation guard for fetch.
- Drives the pipeline-wide stall that freezes all core stage registers while any access is in flight.

---
 rtl/riscv_mem_arbiter_if.sv | 45 ++++
 rtl/riscv_mem_arbiter.sv | 114 +++++++++++
 tb/tb_riscv_mem_arbiter.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_mem_arbiter_if.sv
// Bundle of the fetch, data and backing-memory handshakes around the memory arbiter.
// The slave view belongs to the arbiter; the master view is the core plus the memory.
interface riscv_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_gnt;
    logic              i_rvalid;
    logic [DATA_W-1:0] i_rdata;

    logic              d_req;
    logic [ADDR_W-1:0] d_addr;
    logic [3:0]        d_we;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;

    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_resp_valid;
    logic [DATA_W-1:0] mem_resp_data;

    logic              stall;
    logic              protocol_err;

    modport master (
        output i_req, i_addr, d_req, d_addr, d_we, d_wdata,
               mem_req_ready, mem_resp_valid, mem_resp_data,
        input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
               mem_req_valid, mem_addr, mem_we, mem_wdata, stall, protocol_err
    );

    modport slave (
        input  i_req, i_addr, d_req, d_addr, d_we, d_wdata,
               mem_req_ready, mem_resp_valid, mem_resp_data,
        output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
               mem_req_valid, mem_addr, mem_we, mem_wdata, stall, protocol_err
    );
endinterface

// File: rtl/riscv_mem_arbiter.sv
// Single-outstanding arbiter sharing one memory port between fetch and data, with
// data priority bounded by a streak counter so fetch cannot starve.
module riscv_mem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MAX_D_STREAK = 4
) (
    input  logic               clk,
    input  logic               reset,
    riscv_mem_arbiter_if.slave bus
);
    localparam int CNT_W = $clog2(MAX_D_STREAK + 1);
    localparam logic [CNT_W-1:0] STREAK_MAX = CNT_W'(MAX_D_STREAK);

    typedef enum logic [2:0] {IDLE, ISSUE_D, ISSUE_I, WAIT_D, WAIT_I} state_t;

    state_t            state;
    logic [CNT_W-1:0]  streak;
    logic              mem_req_valid_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [3:0]        mem_we_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic              i_rvalid_q;
    logic              d_rvalid_q;
    logic [DATA_W-1:0] i_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;
    logic              protocol_err_q;

    logic forced;
    logic accept;

    // Fetch wins IDLE arbitration once data has been granted MAX_D_STREAK times in a row.
    assign forced = bus.i_req && (streak == STREAK_MAX);
    assign accept = mem_req_valid_q && bus.mem_req_ready;

    assign bus.i_gnt         = (state == ISSUE_I) && accept;
    assign bus.d_gnt         = (state == ISSUE_D) && accept;
    assign bus.stall         = (state != IDLE) || bus.i_req || bus.d_req;
    assign bus.mem_req_valid = mem_req_valid_q;
    assign bus.mem_addr      = mem_addr_q;
    assign bus.mem_we        = mem_we_q;
    assign bus.mem_wdata     = mem_wdata_q;
    assign bus.i_rvalid      = i_rvalid_q;
    assign bus.d_rvalid      = d_rvalid_q;
    assign bus.i_rdata       = i_rdata_q;
    assign bus.d_rdata       = d_rdata_q;
    assign bus.protocol_err  = protocol_err_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            streak          <= '0;
            mem_req_valid_q <= 1'b0;
            mem_addr_q      <= '0;
            mem_we_q        <= '0;
            mem_wdata_q     <= '0;
            i_rvalid_q      <= 1'b0;
            d_rvalid_q      <= 1'b0;
            i_rdata_q       <= '0;
            d_rdata_q       <= '0;
            protocol_err_q  <= 1'b0;
        end else begin
            i_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.mem_resp_valid) protocol_err_q <= 1'b1;
                    if (bus.d_req && !forced) begin
                        mem_addr_q      <= bus.d_addr;
                        mem_we_q        <= bus.d_we;
                        mem_wdata_q     <= bus.d_wdata;
                        mem_req_valid_q <= 1'b1;
                        state           <= ISSUE_D;
                    end else if (bus.i_req) begin
                        mem_addr_q      <= bus.i_addr;
                        mem_we_q        <= 4'b0000;
                        mem_req_valid_q <= 1'b1;
                        state           <= ISSUE_I;
                    end
                end
                ISSUE_D, ISSUE_I: begin
                    if (bus.mem_resp_valid) protocol_err_q <= 1'b1;
                    if (accept) begin
                        mem_req_valid_q <= 1'b0;
                        if (state == ISSUE_D) begin
                            state <= WAIT_D;
                            // Only data grants that overtake a waiting fetch count toward the streak.
                            if (!bus.i_req)              streak <= '0;
                            else if (streak != STREAK_MAX) streak <= streak + CNT_W'(1);
                        end else begin
                            state  <= WAIT_I;
                            streak <= '0;
                        end
                    end
                end
                WAIT_D: begin
                    if (bus.mem_resp_valid) begin
                        d_rdata_q  <= bus.mem_resp_data;
                        d_rvalid_q <= 1'b1;
                        state      <= IDLE;
                    end
                end
                WAIT_I: begin
                    if (bus.mem_resp_valid) begin
                        i_rdata_q  <= bus.mem_resp_data;
                        i_rvalid_q <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Scoreboard bench for riscv_mem_arbiter: directed stimulus pushes expectations,
// a monitor pops them on grants, memory accepts and read-valid pulses.
module tb_riscv_mem_arbiter;
    typedef logic [95:0] w_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   ready_hold = 0;
    int   resp_delay = 1;
    int   inject_req = 0;
    int   inject_done = 0;

    bit          exp_gnt[$];   // 1 = data grant, 0 = fetch grant
    logic [67:0] exp_req[$];   // {addr, we, wdata-or-0}
    logic [31:0] exp_i[$];
    logic [31:0] exp_d[$];
    logic [31:0] resp_q[$];

    riscv_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    riscv_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_D_STREAK(4)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    function automatic void chk(string name, w_t act, w_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endfunction

    // Backing memory model: configurable ready back-pressure and response delay.
    initial begin
        int phase;
        int waitc;
        int cnt;
        phase = 0; waitc = 0; cnt = 0;
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_data  = 32'h0;
        forever begin
            @(negedge clk);
            bus.mem_resp_valid = 1'b0;
            if (reset) begin
                phase = 0;
                bus.mem_req_ready = 1'b0;
            end else begin
                if (phase == 0 && inject_req != inject_done) begin
                    bus.mem_resp_valid = 1'b1;
                    bus.mem_resp_data  = 32'h0000_0BAD;
                    inject_done++;
                end else if (phase == 0 && bus.mem_req_valid) begin
                    phase = 1;
                    waitc = ready_hold;
                end
                if (phase == 1) begin
                    if (waitc == 0) begin
                        bus.mem_req_ready = 1'b1;
                        phase = 2;
                        cnt = resp_delay;
                    end else begin
                        bus.mem_req_ready = 1'b0;
                        waitc--;
                    end
                end else if (phase == 2) begin
                    bus.mem_req_ready = 1'b0;
                    cnt--;
                    if (cnt <= 0) begin
                        bus.mem_resp_valid = 1'b1;
                        bus.mem_resp_data  = (resp_q.size() != 0) ? resp_q.pop_front() : 32'h0;
                        phase = 0;
                    end
                end
            end
        end
    end

    // Monitor: compares every grant, memory accept and read-valid against the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (!reset) begin
                if (bus.i_gnt || bus.d_gnt) begin
                    if (exp_gnt.size() == 0) chk("gnt_unexpected", w_t'({bus.d_gnt, bus.i_gnt}), w_t'(0));
                    else chk("gnt_order", w_t'({bus.d_gnt, bus.i_gnt}),
                             exp_gnt.pop_front() ? w_t'(2'b10) : w_t'(2'b01));
                end
                if (bus.mem_req_valid && bus.mem_req_ready) begin
                    if (exp_req.size() == 0) chk("req_unexpected", w_t'(bus.mem_addr), w_t'(0));
                    else chk("mem_req_fields",
                             w_t'({bus.mem_addr, bus.mem_we, (bus.mem_we != 4'b0) ? bus.mem_wdata : 32'h0}),
                             w_t'(exp_req.pop_front()));
                end
                if (bus.i_rvalid) begin
                    if (exp_i.size() == 0) chk("i_rvalid_unexpected", w_t'(bus.i_rvalid), w_t'(0));
                    else chk("i_rdata", w_t'(bus.i_rdata), w_t'(exp_i.pop_front()));
                end
                if (bus.d_rvalid) begin
                    if (exp_d.size() == 0) chk("d_rvalid_unexpected", w_t'(bus.d_rvalid), w_t'(0));
                    else chk("d_rdata", w_t'(bus.d_rdata), w_t'(exp_d.pop_front()));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic wait_gnt(input bit is_d);
        int   n = 0;
        logic g = 1'b0;
        while (!g && n < 50) begin
            @(negedge clk); #1; n++;
            g = is_d ? bus.d_gnt : bus.i_gnt;
        end
        chk(is_d ? "d_gnt_seen" : "i_gnt_seen", w_t'(g), w_t'(1));
    endtask

    task automatic wait_rvalid(input bit is_d);
        int   n = 0;
        logic v = 1'b0;
        while (!v && n < 50) begin
            @(negedge clk); #1; n++;
            v = is_d ? bus.d_rvalid : bus.i_rvalid;
        end
        chk(is_d ? "d_rvalid_seen" : "i_rvalid_seen", w_t'(v), w_t'(1));
    endtask

    task automatic do_fetch(input logic [31:0] addr, input logic [31:0] data);
        exp_gnt.push_back(1'b0);
        exp_req.push_back({addr, 4'b0000, 32'h0});
        exp_i.push_back(data);
        resp_q.push_back(data);
        @(negedge clk);
        bus.i_req = 1'b1; bus.i_addr = addr;
        wait_gnt(1'b0);
        bus.i_req = 1'b0;
        wait_rvalid(1'b0);
    endtask

    initial begin
        int n;
        int cyc;
        logic seen;
        reset = 1'b1;
        bus.i_req = 1'b0; bus.i_addr = 32'h0;
        bus.d_req = 1'b0; bus.d_addr = 32'h0; bus.d_we = 4'b0; bus.d_wdata = 32'h0;

        @(negedge clk); #1;
        chk("rst_outputs", w_t'({bus.stall, bus.mem_req_valid, bus.i_gnt, bus.d_gnt,
                                 bus.i_rvalid, bus.d_rvalid, bus.protocol_err}), w_t'(0));
        @(posedge clk); #2; reset = 1'b0;
        @(negedge clk); #1;
        chk("post_rst_idle", w_t'({bus.stall, bus.mem_req_valid, bus.mem_addr, bus.mem_we}), w_t'(0));

        // Single fetch: gnt at N+1, response 2 cycles after accept, rvalid one cycle later.
        resp_delay = 2;
        exp_gnt.push_back(1'b0);
        exp_req.push_back({32'h0000_0100, 4'b0000, 32'h0});
        exp_i.push_back(32'h0000_0013);
        resp_q.push_back(32'h0000_0013);
        @(negedge clk);
        bus.i_req = 1'b1; bus.i_addr = 32'h0000_0100;
        #1;
        chk("f_stall_on_req", w_t'({bus.stall, bus.mem_req_valid}), w_t'(2'b10));
        @(negedge clk); #1;
        chk("f_gnt_n1", w_t'({bus.mem_req_valid, bus.i_gnt}), w_t'(2'b11));
        bus.i_req = 1'b0;
        @(negedge clk); #1;
        chk("f_wait", w_t'({bus.stall, bus.i_gnt, bus.i_rvalid}), w_t'(3'b100));
        @(negedge clk); #1;
        chk("f_resp_cycle", w_t'({bus.stall, bus.i_rvalid, bus.mem_resp_valid}), w_t'(3'b101));
        @(negedge clk); #1;
        chk("f_rvalid", w_t'({bus.i_rvalid, bus.stall}), w_t'(2'b10));
        @(negedge clk); #1;
        chk("f_rvalid_pulse", w_t'(bus.i_rvalid), w_t'(0));

        // Store under 3 cycles of back-pressure.
        resp_delay = 1; ready_hold = 3;
        exp_gnt.push_back(1'b1);
        exp_req.push_back({32'h0000_1000, 4'b0011, 32'hDEAD_BEEF});
        exp_d.push_back(32'h0);
        resp_q.push_back(32'h0);
        @(negedge clk);
        bus.d_req = 1'b1; bus.d_addr = 32'h0000_1000; bus.d_we = 4'b0011; bus.d_wdata = 32'hDEAD_BEEF;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); #1;
            chk("st_held", w_t'({bus.mem_req_valid, bus.d_gnt, bus.mem_addr, bus.mem_we, bus.mem_wdata}),
                w_t'({1'b1, 1'b0, 32'h0000_1000, 4'b0011, 32'hDEAD_BEEF}));
        end
        @(negedge clk); #1;
        chk("st_gnt_on_accept", w_t'(bus.d_gnt), w_t'(1));
        bus.d_req = 1'b0; bus.d_we = 4'b0;
        ready_hold = 0;
        wait_rvalid(1'b1);

        // Back-to-back loads: second request issued the cycle after the first rvalid.
        exp_gnt.push_back(1'b1); exp_req.push_back({32'h0000_2000, 4'b0000, 32'h0});
        exp_d.push_back(32'hA);  resp_q.push_back(32'hA);
        exp_gnt.push_back(1'b1); exp_req.push_back({32'h0000_2004, 4'b0000, 32'h0});
        exp_d.push_back(32'hB);  resp_q.push_back(32'hB);
        @(negedge clk);
        bus.d_req = 1'b1; bus.d_addr = 32'h0000_2000;
        wait_gnt(1'b1);
        bus.d_addr = 32'h0000_2004;
        wait_rvalid(1'b1);
        chk("b2b_idle_at_rvalid", w_t'(bus.mem_req_valid), w_t'(0));
        @(negedge clk); #1;
        chk("b2b_reissue", w_t'({bus.mem_req_valid, bus.d_gnt, bus.d_rvalid, bus.mem_addr}),
            w_t'({3'b110, 32'h0000_2004}));
        bus.d_req = 1'b0;
        wait_rvalid(1'b1);
        @(negedge clk); #1;
        chk("b2b_rvalid_pulse", w_t'(bus.d_rvalid), w_t'(0));

        // Both requesting: order D,D,D,D,I,D with MAX_D_STREAK = 4.
        for (int k = 0; k < 6; k++) begin
            exp_gnt.push_back(k != 4);
            exp_req.push_back({(k != 4) ? 32'h0000_3000 : 32'h0000_4000, 4'b0000, 32'h0});
            resp_q.push_back(32'h100 + k);
            if (k != 4) exp_d.push_back(32'h100 + k);
            else        exp_i.push_back(32'h100 + k);
        end
        @(negedge clk);
        bus.i_req = 1'b1; bus.i_addr = 32'h0000_4000;
        bus.d_req = 1'b1; bus.d_addr = 32'h0000_3000;
        n = 0; cyc = 0;
        while (n < 6 && cyc < 200) begin
            @(negedge clk); #1; cyc++;
            if (bus.i_gnt || bus.d_gnt) n++;
            if (n == 6) begin bus.i_req = 1'b0; bus.d_req = 1'b0; end
        end
        bus.i_req = 1'b0; bus.d_req = 1'b0;
        chk("starve_grant_count", w_t'(n), w_t'(6));
        cyc = 0;
        while ((exp_i.size() + exp_d.size()) != 0 && cyc < 100) begin @(negedge clk); #1; cyc++; end

        // Unexpected response in IDLE.
        @(negedge clk); #1;
        inject_req++;
        @(negedge clk); #1;
        chk("perr_pulse_driven", w_t'(bus.mem_resp_valid), w_t'(1));
        @(negedge clk); #1;
        chk("perr_set", w_t'({bus.protocol_err, bus.i_rvalid, bus.d_rvalid, bus.mem_req_valid, bus.stall}),
            w_t'(5'b10000));
        repeat (3) @(negedge clk);
        #1;
        chk("perr_sticky", w_t'({bus.protocol_err, bus.mem_req_valid}), w_t'(2'b10));

        // Reset while waiting on a data response.
        resp_delay = 20;
        exp_gnt.push_back(1'b1);
        exp_req.push_back({32'h0000_5000, 4'b0000, 32'h0});
        @(negedge clk);
        bus.d_req = 1'b1; bus.d_addr = 32'h0000_5000;
        wait_gnt(1'b1);
        bus.d_req = 1'b0;
        @(negedge clk); #1;
        chk("in_wait_d", w_t'({bus.mem_req_valid, bus.stall}), w_t'(2'b01));
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        chk("rst_async_clear", w_t'({bus.stall, bus.mem_req_valid, bus.d_gnt, bus.d_rvalid,
                                     bus.protocol_err, bus.mem_addr, bus.d_rdata}), w_t'(0));
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
        resp_delay = 1;
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk); #1;
            seen = seen | bus.d_rvalid | bus.i_rvalid | bus.mem_req_valid;
        end
        chk("no_activity_after_rst", w_t'(seen), w_t'(0));
        do_fetch(32'h0000_6000, 32'h0000_0093);

        cyc = 0;
        while ((exp_i.size() + exp_d.size()) != 0 && cyc < 100) begin @(negedge clk); #1; cyc++; end
        @(negedge clk); #1;
        chk("scoreboard_drained", w_t'(exp_gnt.size() + exp_req.size() + exp_i.size() + exp_d.size()), w_t'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
